// File: rtl/uart_instr_loader_if.sv
// Byte-receiver handshake and IMEM write port of the UART instruction loader.
// The master side is the loader; the slave side is the receiver/IMEM pair.
interface uart_instr_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_data_valid;
  logic [7:0]        rx_data;
  logic              rx_finish;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data_valid, rx_data,
    output rx_finish, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data_valid, rx_data,
    input  rx_finish, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_instr_loader.sv
// Boot loader: parses SYNC, LEN_LO, LEN_HI, LEN little-endian words, CSUM from the
// UART byte stream into IMEM. Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module uart_instr_loader #(
  parameter int         ADDR_W         = 10,
  parameter int         BASE_ADDR      = 0,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_instr_loader_if.master bus,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0]       MAX_LEN = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  state_t      state, state_next;
  logic        armed;
  logic        accept;
  logic        restart;
  logic        wr_word;
  logic        timeout_hit;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [23:0] word_lo;

  assign accept = bus.rx_data_valid && armed;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        active;

  assign active      = state inside {LEN0, LEN1, DATA, CSUM};
  assign timeout_hit = active && !accept && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!active || accept || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    wr_word    = 1'b0;
    if (accept) begin
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_next = LEN0;
            restart    = 1'b1;
          end
        end
        LEN0: state_next = LEN1;
        LEN1: begin
          if ({1'b0, bus.rx_data, len_lo} > MAX_LEN) begin
            state_next = ERR;
          end else if ({bus.rx_data, len_lo} == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (byte_idx == 2'd3) begin
            wr_word = 1'b1;
            if (word_cnt + 16'd1 == len) state_next = CSUM;
          end
        end
        CSUM:    state_next = (bus.rx_data == csum) ? DONE : ERR;
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = ERR;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      armed          <= 1'b1;
      bus.rx_finish  <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      word_cnt       <= '0;
      len_lo         <= '0;
      len            <= '0;
      csum           <= '0;
      byte_idx       <= '0;
      word_lo        <= '0;
    end else begin
      state         <= state_next;
      bus.rx_finish <= accept;
      bus.imem_we   <= wr_word;
      cpu_hold      <= (state_next != DONE);
      load_done     <= (state_next == DONE);
      load_err      <= (state_next == ERR);

      // Re-arm only once valid has dropped, so a slow receiver is not consumed twice.
      if (accept) begin
        armed <= 1'b0;
      end else if (!bus.rx_data_valid) begin
        armed <= 1'b1;
      end

      if (restart) begin
        word_cnt <= '0;
        csum     <= '0;
        byte_idx <= '0;
      end

      if (accept && state == LEN0) len_lo <= bus.rx_data;
      if (accept && state == LEN1) len    <= {bus.rx_data, len_lo};

      if (accept && state == DATA) begin
        csum     <= csum + bus.rx_data;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_lo[7:0]   <= bus.rx_data;
          2'd1:    word_lo[15:8]  <= bus.rx_data;
          2'd2:    word_lo[23:16] <= bus.rx_data;
          default: ;
        endcase
        if (wr_word) begin
          bus.imem_addr  <= BASE + word_cnt[ADDR_W-1:0];
          bus.imem_wdata <= {bus.rx_data, word_lo};
          word_cnt       <= word_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Self-checking bench for uart_instr_loader: a frame-position model predicts writes
// and status every cycle; directed frames add literal checks.
module tb_uart_instr_loader;

  localparam int         ADDR_W    = 10;
  localparam int         BASE_ADDR = 0;
  localparam logic [7:0] SYNC      = 8'hA5;
`ifdef LOADER_TIMEOUT_EN
  localparam int         TO_CYC    = 100;
`else
  localparam int         TO_CYC    = 1_000_000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_hold, load_done, load_err;
  logic [15:0] word_cnt;

  uart_instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_instr_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: pos counts bytes into the current frame (0 = hunting for SYNC).
  int          pos;
  int          m_len;
  logic [7:0]  m_sum;
  logic [31:0] m_word;
  logic        m_done, m_err, m_hold;
  int          m_cnt;
  logic        exp_we;
  logic [31:0] exp_addr, exp_data;
  int          acks;
  logic [7:0]  cur_byte;
  bit          chk_en = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  stim[$];

  function automatic void m_reset();
    pos = 0; m_len = 0; m_sum = 0; m_word = 0;
    m_done = 0; m_err = 0; m_hold = 1; m_cnt = 0;
  endfunction

  function automatic void m_finish(input bit ok);
    pos = 0; m_done = ok; m_err = !ok; m_hold = !ok;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    int idx, lane;
    if (pos == 0) begin
      if (b == SYNC) begin
        pos = 1; m_done = 0; m_err = 0; m_hold = 1; m_cnt = 0; m_sum = 0;
      end
    end else if (pos == 1) begin
      m_len = int'(b); pos = 2;
    end else if (pos == 2) begin
      m_len = m_len + int'(b) * 256;
      if (m_len > (1 << ADDR_W)) m_finish(0);
      else pos = 3;
    end else if (pos < 3 + 4 * m_len) begin
      idx  = pos - 3;
      lane = idx % 4;
      m_word[lane*8 +: 8] = b;
      m_sum = m_sum + b;
      if (lane == 3) begin
        exp_we   = 1;
        exp_addr = 32'((BASE_ADDR + idx / 4) % (1 << ADDR_W));
        exp_data = m_word;
        m_cnt    = idx / 4 + 1;
      end
      pos++;
    end else begin
      m_finish(b == m_sum);
    end
  endfunction

  always @(negedge clk) begin
    exp_we = 0;
    if (!rst_n) begin
      m_reset();
    end else if (bus.rx_finish) begin
      acks++;
      m_byte(cur_byte);
    end
    if (bus.imem_we === 1'b1) begin
      log_addr.push_back(32'(bus.imem_addr));
      log_data.push_back(bus.imem_wdata);
    end
    if (chk_en) begin
      check("imem_we", 32'(bus.imem_we), 32'(exp_we));
      if (exp_we && bus.imem_we) begin
        check("imem_addr", 32'(bus.imem_addr), exp_addr);
        check("imem_wdata", bus.imem_wdata, exp_data);
      end
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_err", 32'(load_err), 32'(m_err));
      check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      check("word_cnt", 32'(word_cnt), 32'(m_cnt));
    end
  end

  task automatic send(input logic [7:0] b, input int hold = 2);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    cur_byte = b;
    bus.rx_data = b;
    bus.rx_data_valid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rx_finish) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL ack_timeout: byte %h got no rx_finish, required one", b);
    end
    repeat (hold) @(posedge clk);
    #1 bus.rx_data_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_all();
    foreach (stim[i]) send(stim[i]);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    acks = 0;
    m_reset();
    bus.rx_data_valid = 1'b0;
    bus.rx_data = 8'h00;
    cur_byte = 8'h00;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_rx_finish", 32'(bus.rx_finish), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two words, checksum 0x13+0x93+0x10 = 0xB6.
    stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_all();
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_err", 32'(load_err), 32'd0);
    check("t1_cnt", 32'(word_cnt), 32'd2);
    check("t1_nwr", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("t1_a0", log_addr[0], 32'd0);
      check("t1_d0", log_data[0], 32'h0000_0013);
      check("t1_a1", log_addr[1], 32'd1);
      check("t1_d1", log_data[1], 32'h0010_0093);
    end

    // Same frame with a wrong checksum.
    clear_log();
    stim[11] = 8'hBA;
    send_all();
    check("t2_nwr", 32'(log_addr.size()), 32'd2);
    check("t2_err", 32'(load_err), 32'd1);
    check("t2_hold", 32'(cpu_hold), 32'd1);
    check("t2_done", 32'(load_done), 32'd0);

    // Junk before SYNC, then zero-length frame.
    clear_log();
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_all();
    check("t3_done", 32'(load_done), 32'd1);
    check("t3_nwr", 32'(log_addr.size()), 32'd0);
    check("t3_cnt", 32'(word_cnt), 32'd0);

    // LEN = 0x0401 is one word beyond the IMEM.
    clear_log();
    stim = '{8'hA5, 8'h01, 8'h04};
    send_all();
    check("t4_err", 32'(load_err), 32'd1);
    check("t4_nwr", 32'(log_addr.size()), 32'd0);

    // Valid held long after the ack; SYNC value inside the payload is plain data.
    clear_log();
    a0 = acks;
    send(8'hA5, 5);
    check("t5_one_ack", 32'(acks - a0), 32'd1);
    stim = '{8'h01, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
    send_all();
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_nwr", 32'(log_addr.size()), 32'd1);
    if (log_data.size() == 1) check("t5_d0", log_data[0], 32'h0000_00A5);

    // Reset after 6 payload bytes, then a clean frame.
    clear_log();
    stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_all();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_nwr_partial", 32'(log_addr.size()), 32'd1);
    check("t6_rst_hold", 32'(cpu_hold), 32'd1);
    check("t6_rst_cnt", 32'(word_cnt), 32'd0);
    clear_log();
    stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_all();
    check("t6_done", 32'(load_done), 32'd1);
    check("t6_nwr", 32'(log_addr.size()), 32'd2);
    if (log_data.size() == 2) check("t6_d1", log_data[1], 32'h0010_0093);

`ifdef LOADER_TIMEOUT_EN
    // Stall mid-DATA past the inter-byte timeout.
    clear_log();
    stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_all();
    chk_en = 0;
    repeat (120) @(posedge clk);
    #1;
    check("t7_err", 32'(load_err), 32'd1);
    check("t7_hold", 32'(cpu_hold), 32'd1);
    check("t7_nwr", 32'(log_addr.size()), 32'd0);
    pos = 0; m_err = 1; m_done = 0; m_hold = 1;
    chk_en = 1;
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
